// File: rtl/dmem_dump_ctrl.sv
// dmem_dump_ctrl: post-run DRAM unloader. Once end_process is seen it takes
// the DRAM address port, reads DUMP_WORDS words starting at START_ADDR and
// streams each word high byte first over a valid/ready byte interface.
//
// Ports:
//   clk, reset   - system clock, asynchronous active-high reset
//   end_process  - level from core; high starts the dump
//   mem_sel      - 1 = this block owns the DRAM address port (wren forced low)
//   mem_addr     - DRAM word address while mem_sel=1
//   mem_q        - DRAM read data, valid one cycle after mem_addr
//   tx_data      - byte to UART TX
//   tx_valid     - tx_data valid
//   tx_ready     - UART TX accepts byte on tx_valid & tx_ready
//   busy         - dump in progress
//   done         - dump complete, sticky until reset
module dmem_dump_ctrl #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned DUMP_WORDS = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              end_process,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_q,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  // One extra bit so a full 2^ADDR_W word dump is representable.
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  DUMP_CNT  = CNT_W'(DUMP_WORDS);
  localparam logic [ADDR_W-1:0] START_A   = ADDR_W'(START_ADDR);
  localparam bit                NO_WORDS  = (DUMP_WORDS == 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_SEND_HI,
    S_SEND_LO,
    S_DONE
  } state_t;

  state_t             state, state_d;
  logic [DATA_W-1:0]  word, word_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               mem_sel_d, tx_valid_d, busy_d, done_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic [7:0]         tx_data_d;
  logic               hs_c;
  logic [CNT_W-1:0]   cnt_inc_c;

  assign hs_c      = tx_valid & tx_ready;
  assign cnt_inc_c = cnt + CNT_W'(1);

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      word     <= '0;
      cnt      <= '0;
      mem_sel  <= 1'b0;
      mem_addr <= '0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      word     <= word_d;
      cnt      <= cnt_d;
      mem_sel  <= mem_sel_d;
      mem_addr <= mem_addr_d;
      tx_data  <= tx_data_d;
      tx_valid <= tx_valid_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state;
    word_d     = word;
    cnt_d      = cnt;
    mem_sel_d  = mem_sel;
    mem_addr_d = mem_addr;
    tx_data_d  = tx_data;
    tx_valid_d = tx_valid;
    busy_d     = busy;
    done_d     = done;

    case (state)
      S_IDLE: begin
        // Level-triggered: a high end_process at reset release starts a dump.
        if (end_process) begin
          if (NO_WORDS) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            mem_addr_d = START_A;
            mem_sel_d  = 1'b1;
            busy_d     = 1'b1;
            cnt_d      = '0;
            state_d    = S_ADDR;
          end
        end
      end

      S_ADDR: state_d = S_WAIT;

      S_WAIT: begin
        // DRAM data is valid now; present the high byte straight from mem_q.
        word_d     = mem_q;
        tx_data_d  = mem_q[15:8];
        tx_valid_d = 1'b1;
        state_d    = S_SEND_HI;
      end

      S_SEND_HI: begin
        if (hs_c) begin
          tx_data_d = word[7:0];
          state_d   = S_SEND_LO;
        end
      end

      S_SEND_LO: begin
        if (hs_c) begin
          tx_valid_d = 1'b0;
          cnt_d      = cnt_inc_c;
          if (cnt_inc_c == DUMP_CNT) begin
            mem_sel_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = S_DONE;
          end else begin
            mem_addr_d = mem_addr + ADDR_W'(1);
            state_d    = S_ADDR;
          end
        end
      end

      S_DONE: begin
        mem_sel_d  = 1'b0;
        busy_d     = 1'b0;
        tx_valid_d = 1'b0;
        done_d     = 1'b1;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_dump_ctrl.sv
// Bench for dmem_dump_ctrl: three instances (START=0/N=4, START=FFFE/N=4,
// N=0) share one DRAM model; every accepted byte is checked against the
// byte order derived from the DRAM contents and the dump window.
module tb_dmem_dump_ctrl;

  localparam int unsigned NL = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        end_process;
  logic        mem_sel  [NL];
  logic [15:0] mem_addr [NL];
  logic [15:0] mem_q    [NL];
  logic [7:0]  tx_data  [NL];
  logic        tx_valid [NL];
  logic        tx_ready [NL];
  logic        busy     [NL];
  logic        done     [NL];

  logic [15:0] dram [0:65535];

  int total = 0;
  int bad   = 0;
  int ready_mode;     // 0: ready always high, 1: ready high 30% of cycles
  bit timing_chk;

  dmem_dump_ctrl #(.ADDR_W(16), .DATA_W(16), .START_ADDR(0), .DUMP_WORDS(4)) u_l0 (
    .clk(clk), .reset(rst), .end_process(end_process), .mem_sel(mem_sel[0]),
    .mem_addr(mem_addr[0]), .mem_q(mem_q[0]), .tx_data(tx_data[0]),
    .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .busy(busy[0]), .done(done[0]));

  dmem_dump_ctrl #(.ADDR_W(16), .DATA_W(16), .START_ADDR(65534), .DUMP_WORDS(4)) u_l1 (
    .clk(clk), .reset(rst), .end_process(end_process), .mem_sel(mem_sel[1]),
    .mem_addr(mem_addr[1]), .mem_q(mem_q[1]), .tx_data(tx_data[1]),
    .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .busy(busy[1]), .done(done[1]));

  dmem_dump_ctrl #(.ADDR_W(16), .DATA_W(16), .START_ADDR(0), .DUMP_WORDS(0)) u_l2 (
    .clk(clk), .reset(rst), .end_process(end_process), .mem_sel(mem_sel[2]),
    .mem_addr(mem_addr[2]), .mem_q(mem_q[2]), .tx_data(tx_data[2]),
    .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]), .busy(busy[2]), .done(done[2]));

  always #5 clk = ~clk;

  // DRAM: registered read, data valid one cycle after the address.
  always @(posedge clk) begin
    for (int l = 0; l < NL; l++) mem_q[l] <= dram[mem_addr[l]];
  end

  // Ready driver, changes just after the active edge.
  always @(posedge clk) begin
    #1;
    for (int l = 0; l < NL; l++)
      tx_ready[l] = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lane_start(input int l);
    return (l == 1) ? 16'hFFFE : 16'h0000;
  endfunction

  function automatic int lane_words(input int l);
    return (l == 2) ? 0 : 4;
  endfunction

  // Reference: byte k of a dump is the high/low half of word k/2 of the window.
  function automatic logic [15:0] exp_addr(input int l, input int k);
    return 16'(32'(lane_start(l)) + 32'(k / 2));
  endfunction

  function automatic logic [7:0] exp_byte(input int l, input int k);
    logic [15:0] w;
    w = dram[exp_addr(l, k)];
    return (k % 2 == 0) ? w[15:8] : w[7:0];
  endfunction

  // Compare process state.
  int          nb       [NL];
  int          t_start  [NL];
  bit          p_stall  [NL];
  logic [7:0]  p_data   [NL];
  logic        p_sel    [NL];
  logic        p_done   [NL];
  logic        s_valid  [NL];
  logic        s_ready  [NL];
  logic [7:0]  s_data   [NL];
  logic [15:0] s_addr   [NL];
  logic        s_sel    [NL];
  logic        s_busy   [NL];
  logic        s_done   [NL];
  logic        s_rst;
  int          cyc = 0;
  logic [7:0]  log0 [8];
  logic [15:0] alog1 [4];

  initial begin
    for (int l = 0; l < NL; l++) begin
      nb[l] = 0; t_start[l] = 0; p_stall[l] = 0; p_data[l] = '0; p_sel[l] = 0; p_done[l] = 0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      s_rst = rst;
      for (int l = 0; l < NL; l++) begin
        s_valid[l] = tx_valid[l]; s_ready[l] = tx_ready[l]; s_data[l] = tx_data[l];
        s_addr[l]  = mem_addr[l]; s_sel[l]   = mem_sel[l];  s_busy[l] = busy[l];
        s_done[l]  = done[l];
        if (s_rst) begin
          chk($sformatf("rst_sel%0d", l),   32'(s_sel[l]),   0);
          chk($sformatf("rst_addr%0d", l),  32'(s_addr[l]),  0);
          chk($sformatf("rst_data%0d", l),  32'(s_data[l]),  0);
          chk($sformatf("rst_valid%0d", l), 32'(s_valid[l]), 0);
          chk($sformatf("rst_busy%0d", l),  32'(s_busy[l]),  0);
          chk($sformatf("rst_done%0d", l),  32'(s_done[l]),  0);
        end else begin
          chk($sformatf("busy_eq_sel%0d", l), 32'(s_busy[l]), 32'(s_sel[l]));
          if (s_done[l]) begin
            chk($sformatf("done_valid%0d", l), 32'(s_valid[l]), 0);
            chk($sformatf("done_sel%0d", l),   32'(s_sel[l]),   0);
          end
          if (l == 2) begin
            chk("l2_valid", 32'(s_valid[l]), 0);
            chk("l2_sel",   32'(s_sel[l]),   0);
          end
          if (p_stall[l]) begin
            chk($sformatf("stall_valid%0d", l), 32'(s_valid[l]), 1);
            chk($sformatf("stall_data%0d", l),  32'(s_data[l]),  32'(p_data[l]));
          end
          if (s_sel[l] && !p_sel[l]) t_start[l] = cyc;
          if (s_done[l] && !p_done[l]) begin
            chk($sformatf("done_bytes%0d", l), 32'(nb[l]), 32'(2 * lane_words(l)));
            if (timing_chk && l < 2)
              chk($sformatf("done_lat%0d", l), 32'(cyc - t_start[l]), 16);
          end
        end
      end
      @(posedge clk);
      for (int l = 0; l < NL; l++) begin
        if (rst) begin
          nb[l] = 0; p_stall[l] = 0; p_sel[l] = 0; p_done[l] = 0;
        end else begin
          if (s_valid[l] && s_ready[l]) begin
            if (nb[l] >= 2 * lane_words(l)) begin
              chk($sformatf("extra_byte%0d", l), 32'(nb[l]), 32'(2 * lane_words(l) - 1));
            end else begin
              chk($sformatf("byte%0d_%0d", l, nb[l]), 32'(s_data[l]), 32'(exp_byte(l, nb[l])));
              chk($sformatf("addr%0d_%0d", l, nb[l]), 32'(s_addr[l]), 32'(exp_addr(l, nb[l])));
              if (l == 0) log0[nb[l]] = s_data[l];
              if (l == 1 && nb[l] % 2 == 0) alog1[nb[l] / 2] = s_addr[l];
            end
            nb[l]++;
          end
          p_stall[l] = s_valid[l] && !s_ready[l];
          p_data[l]  = s_data[l];
          p_sel[l]   = s_sel[l];
          p_done[l]  = s_done[l];
        end
      end
    end
  end

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!(done[0] && done[1]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", 32'(done[0] && done[1]), 1);
  endtask

  task automatic pulse_end();
    #2 end_process = 1'b1;
    @(negedge clk);
    #2 end_process = 1'b0;
  endtask

  task automatic rand_dram();
    for (int a = 0; a < 4; a++) dram[a] = 16'($urandom);
    dram[16'hFFFE] = 16'($urandom);
    dram[16'hFFFF] = 16'($urandom);
  endtask

  initial begin
    int n;
    for (int a = 0; a < 65536; a++) dram[a] = '0;
    dram[0] = 16'h1234; dram[1] = 16'hABCD; dram[2] = 16'h0001; dram[3] = 16'hFF00;
    dram[16'hFFFE] = 16'h5A5A; dram[16'hFFFF] = 16'hC3C3;
    rst = 1'b1; end_process = 1'b0; ready_mode = 0; timing_chk = 1'b1;
    for (int l = 0; l < NL; l++) tx_ready[l] = 1'b1;

    // Directed dump with ready held high.
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_sel0", 32'(mem_sel[0]), 0);
    chk("idle_done2", 32'(done[2]), 0);
    pulse_end();
    chk("first_addr_sel0", 32'(mem_sel[0]), 1);
    chk("first_addr0", 32'(mem_addr[0]), 32'h0000);
    chk("first_addr1", 32'(mem_addr[1]), 32'hFFFE);
    chk("zero_words_done2", 32'(done[2]), 1);
    wait_done(200);
    chk("lit_b0", 32'(log0[0]), 32'h12); chk("lit_b1", 32'(log0[1]), 32'h34);
    chk("lit_b2", 32'(log0[2]), 32'hAB); chk("lit_b3", 32'(log0[3]), 32'hCD);
    chk("lit_b4", 32'(log0[4]), 32'h00); chk("lit_b5", 32'(log0[5]), 32'h01);
    chk("lit_b6", 32'(log0[6]), 32'hFF); chk("lit_b7", 32'(log0[7]), 32'h00);
    chk("lit_a0", 32'(alog1[0]), 32'hFFFE); chk("lit_a1", 32'(alog1[1]), 32'hFFFF);
    chk("lit_a2", 32'(alog1[2]), 32'h0000); chk("lit_a3", 32'(alog1[3]), 32'h0001);
    chk("after_sel0", 32'(mem_sel[0]), 0);

    // A second end_process after done must not start another dump.
    #2 end_process = 1'b1;
    repeat (3) @(negedge clk);
    #2 end_process = 1'b0;
    repeat (10) @(negedge clk);
    for (int l = 0; l < NL; l++) chk($sformatf("sticky_done%0d", l), 32'(done[l]), 1);
    chk("no_redump0", 32'(nb[0]), 8);
    chk("no_redump1", 32'(nb[1]), 8);

    // Randomized data with 30% ready.
    timing_chk = 1'b0;
    for (int r = 0; r < 4; r++) begin
      #2 rst = 1'b1;
      rand_dram();
      ready_mode = 1;
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      pulse_end();
      wait_done(600);
      chk($sformatf("rand_bytes0_%0d", r), 32'(nb[0]), 8);
      chk($sformatf("rand_bytes1_%0d", r), 32'(nb[1]), 8);
    end

    // end_process already high at reset release, then reset mid SEND_LO of word 2.
    #2 rst = 1'b1;
    rand_dram();
    ready_mode = 0;
    end_process = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rel_sel0", 32'(mem_sel[0]), 1);
    chk("rel_sel1", 32'(mem_sel[1]), 1);
    chk("rel_done2", 32'(done[2]), 1);
    n = 0;
    while (!(tx_valid[0] && nb[0] == 5) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_lo2", 32'(tx_valid[0] && nb[0] == 5), 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", 32'(tx_valid[0]), 0);
    chk("midrst_sel",   32'(mem_sel[0]),  0);
    chk("midrst_busy",  32'(busy[0]),     0);
    chk("midrst_done",  32'(done[0]),     0);
    chk("midrst_done2", 32'(done[2]),     0);
    ready_mode = 1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    wait_done(600);
    chk("restart_bytes0", 32'(nb[0]), 8);
    chk("restart_bytes1", 32'(nb[1]), 8);
    end_process = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_dump_ctrl.md
Name: dmem_dump_ctrl

Overview:
- Post-run result unloader that sits downstream of the processor top.
- Once the core raises end_process, the block takes ownership of the DRAM address port and reads a fixed window of 16-bit words. Each word is streamed as two bytes over a valid/ready byte interface that feeds the board UART transmitter.
- The core is halted while the block is active; the DRAM address/write-enable mux is driven by mem_sel.

Parameters:
ADDR_W, 16, DRAM address width
DATA_W, 16, DRAM word width; fixed at 16 (two bytes per word)
START_ADDR, 0, first DRAM word address dumped
DUMP_WORDS, 256, number of words dumped; range 0..2^ADDR_W

Ports:
clk  in  1  system clock, same clock as IRAM/DRAM/core
reset  in  1  asynchronous, active-high reset
end_process  in  1  level from core; high means the program has finished
mem_sel  out  1  1 = this block owns the DRAM address port, forces DRAM wren low
mem_addr  out  ADDR_W  DRAM word address while mem_sel=1
mem_q  in  DATA_W  DRAM read data; valid exactly 1 cycle after mem_addr is presented
tx_data  out  8  byte to UART TX
tx_valid  out  1  tx_data valid
tx_ready  in  1  UART TX accepts byte when tx_valid & tx_ready
busy  out  1  dump in progress
done  out  1  dump complete; sticky until reset

Behaviour:
- Reset (asynchronous, any state, including mid-dump):
  - state=IDLE
  - mem_sel=0, mem_addr=0, tx_data=0, tx_valid=0, busy=0, done=0
  - word counter=0
  - Any byte in flight is dropped; no partial handshake completes.
- FSM states: IDLE, ADDR, WAIT, SEND_HI, SEND_LO, DONE.
- IDLE:
  - Sample end_process each cycle. A level, not an edge, triggers the dump, so a high level at reset release starts a dump.
  - If DUMP_WORDS=0 -> DONE directly. Otherwise mem_addr<=START_ADDR, mem_sel<=1, busy<=1, go to ADDR.
- ADDR: address is on the DRAM port this cycle -> WAIT.
- WAIT: capture mem_q into the 16-bit word register, load tx_data<=word[15:8], tx_valid<=1 -> SEND_HI.
- SEND_HI:
  - Hold tx_valid and tx_data stable until tx_ready.
  - On handshake: tx_data<=word[7:0], tx_valid stays 1 -> SEND_LO. There is no idle cycle between the two bytes of a word.
- SEND_LO, on handshake:
  - tx_valid<=0, counter+1.
  - If counter+1 == DUMP_WORDS -> DONE.
  - Else mem_addr<=mem_addr+1 (mod 2^ADDR_W) -> ADDR.
- DONE: mem_sel=0, busy=0, done=1, tx_valid=0. Remains until reset; end_process is ignored.
- Handshake rules:
  - tx_valid never deasserts without a handshake.
  - tx_data is never changed while tx_valid=1 and tx_ready=0.
  - tx_ready is ignored while tx_valid=0.
- Throughput: best case 4 cycles per word with tx_ready held high (ADDR, WAIT, SEND_HI, SEND_LO).
- Ordering: words in ascending address order, high byte first.
- Address wrap: START_ADDR+DUMP_WORDS beyond 2^ADDR_W wraps to 0 and continues.
- Counter width: ADDR_W+1 bits, so DUMP_WORDS=2^ADDR_W is representable.
- end_process falling mid-dump has no effect; the dump always runs to completion.
- mem_sel is high from the cycle after the trigger through the final SEND_LO handshake cycle inclusive. It drops in the same cycle that done rises.

Test Plan:
- START_ADDR=0, DUMP_WORDS=4, DRAM[0..3]=0x1234,0xABCD,0x0001,0xFF00, tx_ready=1, pulse end_process -> bytes 12,34,AB,CD,00,01,FF,00 in order; done rises 16 cycles after the first ADDR cycle; mem_sel=0 after.
- Same setup, tx_ready toggles with a random 30% duty -> identical byte stream; tx_data stable while tx_valid=1 and tx_ready=0; no byte duplicated or lost.
- START_ADDR=0xFFFE, DUMP_WORDS=4 -> mem_addr sequence FFFE, FFFF, 0000, 0001; 8 bytes out; done=1.
- end_process already high when reset deasserts -> dump starts in the first cycle after reset release. A later end_process toggle after done -> no second dump; done stays 1.
- Assert reset during SEND_LO of word 2 -> same cycle: tx_valid=0, mem_sel=0, busy=0, done=0. After release with end_process high -> dump restarts from START_ADDR.
- DUMP_WORDS=0 -> no tx_valid ever; mem_sel stays 0; done=1 one cycle after end_process is seen.
